// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM controller:
// FSM state codes, ALU op codes, data-processing commands and condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_RSB = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;
  localparam logic [3:0] ALU_EOR = 4'b0111;
  localparam logic [3:0] ALU_BIC = 4'b1010;
  localparam logic [3:0] ALU_MVN = 4'b1110;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_BIC = 4'b1110;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;

endpackage

// File: rtl/arm_condcheck.sv
// ARM condition-field evaluator against the stored {N,Z,C,V} flags.
// Code 1111 behaves as AL.
module arm_condcheck
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b1;
    unique case (cond)
      CC_EQ:   cond_ex = z;
      CC_NE:   cond_ex = ~z;
      CC_CS:   cond_ex = c;
      CC_CC:   cond_ex = ~c;
      CC_MI:   cond_ex = n;
      CC_PL:   cond_ex = ~n;
      CC_VS:   cond_ex = v;
      CC_VC:   cond_ex = ~v;
      CC_HI:   cond_ex = c & ~z;
      CC_LS:   cond_ex = ~c | z;
      CC_GE:   cond_ex = ~(n ^ v);
      CC_LT:   cond_ex = n ^ v;
      CC_GT:   cond_ex = ~z & ~(n ^ v);
      CC_LE:   cond_ex = z | (n ^ v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: FSM with memory wait states, ALU decode, flags.
// Optional SHIFT_EN macro enables MOV shift decoding on RegControl.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int MEM_LAT   = 0,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           RegControl,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [3:0] state, state_nx, cnt, flags;
  logic [3:0] cmd, alu_op;
  logic [5:0] funct;
  logic [1:0] op, flag_w;
  logic       cond_ex, no_write, waits, fin, exec, reg_w;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign waits = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign fin   = ~waits || (cnt == LAT);
  assign exec  = (state == EXECR) || (state == EXECI);

  arm_condcheck u_cond (
    .cond    (Instr[31:28]),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  always_comb begin
    state_nx = FETCH;
    unique case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        unique case (op)
          2'b00:   state_nx = funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR:       state_nx = funct[0] ? MEMRD : MEMWR;
      MEMRD:        state_nx = MEMWB;
      EXECR, EXECI: state_nx = ALUWB;
      default:      state_nx = FETCH;
    endcase
    if (!fin) state_nx = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= 4'd0;
      flags <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= fin ? 4'd0 : cnt + 4'd1;
      if (exec && cond_ex && flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (exec && cond_ex && flag_w[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    alu_op = ALU_ADD;
    flag_w = 2'b00;
    if (exec) begin
      unique case (cmd)
        CMD_ADD: begin alu_op = ALU_ADD; flag_w = {2{funct[0]}}; end
        CMD_SUB: begin alu_op = ALU_SUB; flag_w = {2{funct[0]}}; end
        CMD_RSB: begin alu_op = ALU_RSB; flag_w = {2{funct[0]}}; end
        CMD_AND: begin alu_op = ALU_AND; flag_w = {funct[0], 1'b0}; end
        CMD_ORR: begin alu_op = ALU_ORR; flag_w = {funct[0], 1'b0}; end
        CMD_EOR: begin alu_op = ALU_EOR; flag_w = {funct[0], 1'b0}; end
        CMD_MOV: begin alu_op = ALU_MOV; flag_w = {funct[0], 1'b0}; end
        CMD_BIC: begin alu_op = ALU_BIC; flag_w = {funct[0], 1'b0}; end
        CMD_MVN: begin alu_op = ALU_MVN; flag_w = {funct[0], 1'b0}; end
        CMD_CMP: begin alu_op = ALU_SUB; flag_w = 2'b11; end
        CMD_CMN: begin alu_op = ALU_ADD; flag_w = 2'b11; end
        CMD_TST: begin alu_op = ALU_AND; flag_w = 2'b11; end
        CMD_TEQ: begin alu_op = ALU_EOR; flag_w = 2'b11; end
        default: begin alu_op = ALU_ADD; flag_w = 2'b00; end
      endcase
    end
  end

  // compares are decoded from Instr directly so ALUWB still sees them
  assign no_write = (op == 2'b00) && (cmd[3:2] == 2'b10);

  always_comb begin
    ALUControl      = '0;
    ALUControl[3:0] = alu_op;
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    unique case (state)
      FETCH, DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR, EXECI: ALUSrcB = 2'b01;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      MEMRD, MEMWR: AdrSrc = 1'b1;
      MEMWB:        ResultSrc = 2'b01;
      default:      ResultSrc = 2'b00;
    endcase
  end

  assign reg_w = ((state == MEMWB) || (state == ALUWB))
                 && cond_ex && ~no_write;

  assign RegWrite = reset && reg_w;
  assign MemWrite = reset && (state == MEMWR) && fin && cond_ex;
  assign IRWrite  = reset && (state == FETCH) && fin;
  assign PCWrite  = reset && (((state == FETCH) && fin)
                    || ((state == BRANCH) && cond_ex)
                    || (reg_w && (Instr[15:12] == 4'hf)));

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01) && ~funct[0], op == 2'b10};
  assign State  = state;

`ifdef SHIFT_EN
  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[3:0]};

  // shift type 11 (ROR) has no RegControl code and falls back to plain MOV
  always_comb begin
    RegControl = 2'b00;
    if ((op == 2'b00) && (cmd == CMD_MOV) && ~funct[5]
        && (Instr[11:4] != 8'd0) && (Instr[6:5] != 2'b11))
      RegControl = Instr[6:5] + 2'b01;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};
  assign RegControl  = 2'b00;
`endif

endmodule
